// File: rtl/store_buffer.sv
// Store buffer: formats SW/SH/SB into lane-replicated data plus byte enables, queues them
// in a DEPTH-entry FIFO, drains to memory over req/ack, and flags load-after-store hazards.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          st_valid,
    input  logic [1:0]    st_op,
    input  logic [AW-1:0] st_addr,
    input  logic [31:0]   st_data,
    output logic          st_ready,
    output logic          st_err,
    input  logic          ld_check,
    input  logic [AW-1:0] ld_addr,
    output logic          ld_hit,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_be,
    input  logic          mem_ack,
    output logic          empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        OP_SW  = 2'b00,
        OP_SH  = 2'b01,
        OP_SB  = 2'b10,
        OP_RSV = 2'b11
    } st_op_e;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          st_err_q, st_err_d;

    logic [AW-3:0] ent_addr_q [DEPTH];
    logic [31:0]   ent_data_q [DEPTH];
    logic [3:0]    ent_be_q   [DEPTH];

    logic          legal;
    logic          push;
    logic          pop;
    logic [31:0]   fmt_data;
    logic [3:0]    fmt_be;
    logic [PW-1:0] slot_off;
    logic [DEPTH-1:0] ent_valid;
    logic [DEPTH-1:0] ent_match;

    // Load address offset bits never matter: hazards are tracked per word.
    logic unused_ld_lsb;
    assign unused_ld_lsb = ^ld_addr[1:0];

    // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        fmt_data = st_data;
        fmt_be   = 4'b1111;
        legal    = 1'b0;
        case (st_op_e'(st_op))
            OP_SW: begin
                legal = (st_addr[1:0] == 2'b00);
            end
            OP_SH: begin
                fmt_data = {2{st_data[15:0]}};
                fmt_be   = st_addr[1] ? 4'b1100 : 4'b0011;
                legal    = !st_addr[0];
            end
            OP_SB: begin
                fmt_data = {4{st_data[7:0]}};
                fmt_be   = 4'b0001 << st_addr[1:0];
                legal    = 1'b1;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

    // Full-ness depends on count alone, so a pop in the same cycle never frees a slot for a push.
    assign st_ready = (count_q != FULL_CNT);
    assign empty    = (count_q == '0);
    assign push     = st_valid & st_ready & legal;
    assign pop      = !empty & mem_ack;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
        st_err_d = st_valid & !legal;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            st_err_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            st_err_q <= st_err_d;
        end
    end

    // NOTE: the storage array has no reset; validity comes from the pointers and count, which are reset.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_addr_q[wr_ptr_q] <= st_addr[AW-1:2];
            ent_data_q[wr_ptr_q] <= fmt_data;
            ent_be_q[wr_ptr_q]   <= fmt_be;
        end
    end

    // A slot is live when its distance from the head is below the occupancy count.
    always_comb begin
        slot_off  = '0;
        ent_valid = '0;
        ent_match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_off     = PW'(i) - rd_ptr_q;
            ent_valid[i] = ({1'b0, slot_off} < count_q);
            ent_match[i] = (ent_addr_q[i] == ld_addr[AW-1:2]);
        end
    end

    assign ld_hit    = ld_check & |(ent_valid & ent_match);
    assign st_err    = st_err_q;
    assign mem_req   = !empty;
    assign mem_addr  = empty ? '0 : {ent_addr_q[rd_ptr_q], 2'b00};
    assign mem_wdata = empty ? '0 : ent_data_q[rd_ptr_q];
    assign mem_be    = empty ? '0 : ent_be_q[rd_ptr_q];

endmodule
